// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the 24-bit XNOR pattern generator and its checker.
// The generator and checker both step the register through lfsr_next().
package lfsr_pkg;

    localparam int LFSR_WIDTH = 24;
    localparam int LFSR_TAP_A = 23;
    localparam int LFSR_TAP_B = 18;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    function automatic logic lfsr_feedback(input logic [LFSR_WIDTH-1:0] s);
        return ~(s[LFSR_TAP_A] ^ s[LFSR_TAP_B]);
    endfunction

    // All-ones is the XNOR lockup state and is never produced by a running source.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s);
        return {s[LFSR_WIDTH-2:0], lfsr_feedback(s)};
    endfunction

endpackage

// File: rtl/lfsr_prbs_checker_if.sv
// Stream, count-clear and status bundle between a pattern source / display logic and the checker.
// The master drives the bit stream; the slave (checker) drives lock and error status.
interface lfsr_prbs_checker_if #(
    parameter int CNT_WIDTH = 16
);

    logic                 i_Data_Valid;
    logic                 i_Data;
    logic                 i_Clear_Count;
    logic                 o_Locked;
    logic                 o_Bit_Error;
    logic                 o_Lock_Lost;
    logic [CNT_WIDTH-1:0] o_Error_Count;

    modport master (
        output i_Data_Valid,
        output i_Data,
        output i_Clear_Count,
        input  o_Locked,
        input  o_Bit_Error,
        input  o_Lock_Lost,
        input  o_Error_Count
    );

    modport slave (
        input  i_Data_Valid,
        input  i_Data,
        input  i_Clear_Count,
        output o_Locked,
        output o_Bit_Error,
        output o_Lock_Lost,
        output o_Error_Count
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear and increment together yield 1
// so an event landing on the clear cycle is not lost.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Inc,
    input  logic             i_Clear,
    output logic [WIDTH-1:0] o_Count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_Count <= '0;
        end else if (i_Clear) begin
            o_Count <= i_Inc ? ONE : '0;
        end else if (i_Inc && (o_Count != '1)) begin
            o_Count <= o_Count + ONE;
        end
    end

endmodule

// File: rtl/lfsr_prbs_checker.sv
// Receive-side checker for the XNOR LFSR bit source: seeds a local register from the
// stream, confirms lock, then flags and counts mismatches against its own prediction.
//
// state  | meaning
// SEED   | shifting received bits into s until WIDTH bits are collected
// VERIFY | self-synchronising; counting consecutive correct predictions
// LOCKED | free-running on predictions; received bits only compared, never shifted in
module lfsr_prbs_checker
    import lfsr_pkg::*;
#(
    parameter int WIDTH        = LFSR_WIDTH,
    parameter int TAP_A        = LFSR_TAP_A,
    parameter int TAP_B        = LFSR_TAP_B,
    parameter int LOCK_MATCHES = 8,
    parameter int WINDOW       = 64,
    parameter int LOSS_ERRORS  = 4,
    parameter int CNT_WIDTH    = 16
) (
    input logic               i_Clk,
    input logic               i_Rst,
    lfsr_prbs_checker_if.slave bus
);

    localparam int FILL_W  = $clog2(WIDTH + 1);
    localparam int MATCH_W = $clog2(LOCK_MATCHES + 1);
    localparam int WIN_W   = $clog2(WINDOW + 1);
    localparam int WERR_W  = $clog2(LOSS_ERRORS + 1);

    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(WIDTH - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_MATCHES - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW - 1);
    localparam logic [WERR_W-1:0]  WERR_LAST  = WERR_W'(LOSS_ERRORS - 1);

    chk_state_t           state;
    logic [WIDTH-1:0]     s;
    logic [FILL_W-1:0]    fill_cnt;
    logic [MATCH_W-1:0]   match_cnt;
    logic [WIN_W-1:0]     win_cnt;
    logic [WERR_W-1:0]    werr_cnt;
    logic                 locked_q;
    logic                 bit_error_q;
    logic                 lock_lost_q;
    logic [CNT_WIDTH-1:0] error_count;

    logic             predicted;
    logic             bit_mismatch;
    logic [WIDTH-1:0] s_shift_in;
    logic [WIDTH-1:0] s_free_run;
    logic             count_inc;

    assign predicted    = ~(s[TAP_A] ^ s[TAP_B]);
    assign bit_mismatch = bus.i_Data ^ predicted;
    assign s_shift_in   = {s[WIDTH-2:0], bus.i_Data};

    // Share the generator's step function whenever the checker runs the default polynomial.
    if (WIDTH == LFSR_WIDTH && TAP_A == LFSR_TAP_A && TAP_B == LFSR_TAP_B) begin : g_pkg_step
        assign s_free_run = lfsr_next(s);
    end else begin : g_param_step
        assign s_free_run = {s[WIDTH-2:0], predicted};
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state       <= SEED;
            s           <= '0;
            fill_cnt    <= '0;
            match_cnt   <= '0;
            win_cnt     <= '0;
            werr_cnt    <= '0;
            locked_q    <= 1'b0;
            bit_error_q <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            bit_error_q <= 1'b0;
            lock_lost_q <= 1'b0;
            if (bus.i_Data_Valid) begin
                unique case (state)
                    SEED: begin
                        s <= s_shift_in;
                        if (fill_cnt == FILL_LAST) begin
                            fill_cnt <= '0;
                            if (!(&s_shift_in)) begin
                                state     <= VERIFY;
                                match_cnt <= '0;
                            end
                        end else begin
                            fill_cnt <= fill_cnt + FILL_W'(1);
                        end
                    end

                    VERIFY: begin
                        s <= s_shift_in;
                        if (bit_mismatch) begin
                            match_cnt <= '0;
                        end else if (match_cnt == MATCH_LAST) begin
                            state     <= LOCKED;
                            locked_q  <= 1'b1;
                            match_cnt <= '0;
                            win_cnt   <= '0;
                            werr_cnt  <= '0;
                        end else begin
                            match_cnt <= match_cnt + MATCH_W'(1);
                        end
                    end

                    LOCKED: begin
                        s           <= s_free_run;
                        bit_error_q <= bit_mismatch;
                        // Loss wins over a window rollover landing on the same bit.
                        if (bit_mismatch && (werr_cnt == WERR_LAST)) begin
                            state       <= SEED;
                            fill_cnt    <= '0;
                            locked_q    <= 1'b0;
                            lock_lost_q <= 1'b1;
                            win_cnt     <= '0;
                            werr_cnt    <= '0;
                        end else if (win_cnt == WIN_LAST) begin
                            win_cnt  <= '0;
                            werr_cnt <= '0;
                        end else begin
                            win_cnt <= win_cnt + WIN_W'(1);
                            if (bit_mismatch) begin
                                werr_cnt <= werr_cnt + WERR_W'(1);
                            end
                        end
                    end

                    default: begin
                        state    <= SEED;
                        fill_cnt <= '0;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign count_inc = bus.i_Data_Valid && (state == LOCKED) && bit_mismatch;

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_err_cnt (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Inc   (count_inc),
        .i_Clear (bus.i_Clear_Count),
        .o_Count (error_count)
    );

    assign bus.o_Locked      = locked_q;
    assign bus.o_Bit_Error   = bit_error_q;
    assign bus.o_Lock_Lost   = lock_lost_q;
    assign bus.o_Error_Count = error_count;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Bench for lfsr_prbs_checker: a 16-bit-count and a 4-bit-count instance see the same
// randomly gapped stream and are compared every cycle against a queue-based reference.
module tb_lfsr_prbs_checker;

    localparam int W     = 24;
    localparam int LOCKN = 8;
    localparam int WIN   = 64;
    localparam int LOSS  = 4;

    localparam int PH_FILL    = 0;
    localparam int PH_CONFIRM = 1;
    localparam int PH_TRACK   = 2;

    logic i_Clk = 1'b0;
    logic i_Rst;

    always #5 i_Clk = ~i_Clk;

    lfsr_prbs_checker_if #(.CNT_WIDTH(16)) bus_a ();
    lfsr_prbs_checker_if #(.CNT_WIDTH(4))  bus_b ();

    lfsr_prbs_checker #(.CNT_WIDTH(16)) dut_a (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .bus   (bus_a.slave)
    );

    lfsr_prbs_checker #(.CNT_WIDTH(4)) dut_b (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .bus   (bus_b.slave)
    );

    int checks = 0;
    int errors = 0;

    bit gen_q[$];
    bit ref_q[$];
    int m_phase, m_fill, m_match, m_win, m_werr, m_raw;
    bit m_locked, m_biterr, m_lost;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    task automatic gen_reset();
        gen_q = {};
        repeat (W) gen_q.push_back(1'b0);
    endtask

    // Generator output is the newly formed bit: oldest-of-24 XNOR oldest-of-19.
    task automatic gen_bit(output bit b);
        b = ~(gen_q[0] ^ gen_q[5]);
        gen_q.push_back(b);
        void'(gen_q.pop_front());
    endtask

    task automatic model_reset();
        ref_q = {};
        repeat (W) ref_q.push_back(1'b0);
        m_phase = PH_FILL; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0; m_raw = 0;
        m_locked = 1'b0; m_biterr = 1'b0; m_lost = 1'b0;
    endtask

    function automatic bit model_pred();
        return ~(ref_q[0] ^ ref_q[5]);
    endfunction

    task automatic model_push(input bit b);
        ref_q.push_back(b);
        void'(ref_q.pop_front());
    endtask

    task automatic model_step(input bit valid, input bit b, input bit clr);
        bit p, err, ones;
        err = 1'b0;
        m_biterr = 1'b0;
        m_lost = 1'b0;
        if (valid) begin
            p = model_pred();
            if (m_phase == PH_FILL) begin
                model_push(b);
                m_fill++;
                if (m_fill == W) begin
                    m_fill = 0;
                    ones = 1'b1;
                    foreach (ref_q[i]) ones &= ref_q[i];
                    if (!ones) begin m_phase = PH_CONFIRM; m_match = 0; end
                end
            end else if (m_phase == PH_CONFIRM) begin
                m_match = (b == p) ? m_match + 1 : 0;
                model_push(b);
                if (m_match == LOCKN) begin
                    m_phase = PH_TRACK; m_locked = 1'b1; m_win = 0; m_werr = 0;
                end
            end else begin
                model_push(p);
                m_win++;
                if (b != p) begin err = 1'b1; m_biterr = 1'b1; m_werr++; end
                if (m_werr == LOSS) begin
                    m_phase = PH_FILL; m_fill = 0; m_locked = 1'b0; m_lost = 1'b1;
                end else if (m_win == WIN) begin
                    m_win = 0; m_werr = 0;
                end
            end
        end
        if (clr) m_raw = err ? 1 : 0;
        else if (err) m_raw++;
    endtask

    task automatic compare_all();
        chk("locked_a", 32'(bus_a.o_Locked),      32'(m_locked));
        chk("biterr_a", 32'(bus_a.o_Bit_Error),   32'(m_biterr));
        chk("lost_a",   32'(bus_a.o_Lock_Lost),   32'(m_lost));
        chk("count_a",  32'(bus_a.o_Error_Count), 32'(sat(m_raw, 65535)));
        chk("locked_b", 32'(bus_b.o_Locked),      32'(m_locked));
        chk("biterr_b", 32'(bus_b.o_Bit_Error),   32'(m_biterr));
        chk("lost_b",   32'(bus_b.o_Lock_Lost),   32'(m_lost));
        chk("count_b",  32'(bus_b.o_Error_Count), 32'(sat(m_raw, 15)));
    endtask

    task automatic drive(input bit valid, input bit b, input bit clr);
        bus_a.i_Data_Valid = valid; bus_a.i_Data = b; bus_a.i_Clear_Count = clr;
        bus_b.i_Data_Valid = valid; bus_b.i_Data = b; bus_b.i_Clear_Count = clr;
    endtask

    task automatic cycle(input bit valid, input bit b, input bit clr);
        @(negedge i_Clk);
        drive(valid, b, clr);
        @(posedge i_Clk);
        #1;
        model_step(valid, b, clr);
        compare_all();
    endtask

    task automatic send(input bit b, input bit clr);
        if ($urandom_range(0, 3) == 0) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        cycle(1'b1, b, clr);
    endtask

    task automatic send_gen(input bit flip, input bit clr);
        bit g;
        gen_bit(g);
        send(g ^ flip, clr);
    endtask

    task automatic relock(input string tag);
        for (int n = 1; n <= W + LOCKN; n++) begin
            send_gen(1'b0, 1'b0);
            if (n == W + LOCKN - 1) chk({tag, "_not_early"}, 32'(bus_a.o_Locked), 32'd0);
        end
        chk({tag, "_at_32"}, 32'(bus_a.o_Locked), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge i_Clk);
        drive(1'b0, 1'b0, 1'b0);
        i_Rst = 1'b1;
        @(posedge i_Clk);
        #1;
        model_reset();
        compare_all();
        @(negedge i_Clk);
        i_Rst = 1'b0;
    endtask

    initial begin
        int a1, a2, b1, b2;
        bit f;

        i_Rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        gen_reset();
        model_reset();
        repeat (3) @(posedge i_Clk);
        #1;
        compare_all();
        @(negedge i_Clk);
        i_Rst = 1'b0;

        // Clean lock and long clean run.
        relock("lock");
        repeat (10000) send_gen(1'b0, 1'b0);
        chk("clean_count", 32'(bus_a.o_Error_Count), 32'd0);

        // Single error on locked bit 100 of a fresh segment.
        repeat (99) send_gen(1'b0, 1'b0);
        send_gen(1'b1, 1'b0);
        chk("single_pulse", 32'(bus_a.o_Bit_Error), 32'd1);
        chk("single_count", 32'(bus_a.o_Error_Count), 32'd1);
        repeat (100) send_gen(1'b0, 1'b0);
        chk("single_still_locked", 32'(bus_a.o_Locked), 32'd1);
        chk("single_count_after", 32'(bus_a.o_Error_Count), 32'd1);

        // Four flips inside one window drop lock.
        while (m_win != 0) send_gen(1'b0, 1'b0);
        for (int k = 0; k < LOSS; k++) begin
            repeat ($urandom_range(0, 12)) send_gen(1'b0, 1'b0);
            send_gen(1'b1, 1'b0);
        end
        chk("loss_pulse", 32'(bus_a.o_Lock_Lost), 32'd1);
        chk("loss_unlocked", 32'(bus_a.o_Locked), 32'd0);
        chk("loss_count", 32'(bus_a.o_Error_Count), 32'd5);
        relock("relock");

        // Three flips in each of two adjacent windows, including the last and first bits.
        while (m_win != 0) send_gen(1'b0, 1'b0);
        a1 = $urandom_range(0, 30);  a2 = $urandom_range(31, 62);
        b1 = $urandom_range(65, 95); b2 = $urandom_range(96, 127);
        for (int i = 0; i < 2 * WIN; i++) begin
            f = (i == 63) || (i == 64) || (i == a1) || (i == a2) || (i == b1) || (i == b2);
            send_gen(f, 1'b0);
        end
        chk("window_locked", 32'(bus_a.o_Locked), 32'd1);
        chk("window_count", 32'(bus_a.o_Error_Count), 32'd11);

        // Twenty spaced errors: narrow counter pins at 15, wide one keeps counting.
        repeat (20) begin
            repeat ($urandom_range(25, 40)) send_gen(1'b0, 1'b0);
            send_gen(1'b1, 1'b0);
        end
        chk("sat_count_b", 32'(bus_b.o_Error_Count), 32'd15);
        chk("sat_count_a", 32'(bus_a.o_Error_Count), 32'd31);
        chk("sat_locked", 32'(bus_a.o_Locked), 32'd1);
        repeat (30) send_gen(1'b0, 1'b0);
        send_gen(1'b1, 1'b1);
        chk("clear_err_a", 32'(bus_a.o_Error_Count), 32'd1);
        chk("clear_err_b", 32'(bus_b.o_Error_Count), 32'd1);
        repeat (30) send_gen(1'b0, 1'b0);
        send_gen(1'b0, 1'b1);
        chk("clear_only_a", 32'(bus_a.o_Error_Count), 32'd0);
        chk("clear_only_b", 32'(bus_b.o_Error_Count), 32'd0);

        // All-ones stream never gets past seeding.
        do_reset();
        repeat (300) send(1'b1, 1'b0);
        chk("ones_unlocked", 32'(bus_a.o_Locked), 32'd0);
        chk("ones_count", 32'(bus_a.o_Error_Count), 32'd0);

        // Asynchronous reset between edges while an error pulse is showing.
        do_reset();
        gen_reset();
        relock("pre_rst");
        repeat (20) send_gen(1'b0, 1'b0);
        send_gen(1'b1, 1'b0);
        chk("pre_rst_pulse", 32'(bus_a.o_Bit_Error), 32'd1);
        #2;
        i_Rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge i_Clk);
        drive(1'b0, 1'b0, 1'b0);
        i_Rst = 1'b0;
        relock("post_rst");
        repeat (50) send_gen(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
